rotation_angle_gen: RTL and testbench
=====================================

ROTATION_ANGLE_GEN -- requirements
Module: rotation_angle_gen

Interface
REQ-001 SHALL have parameter N_AXES, default 3, number of independent rotation axes (1..8).
REQ-002 SHALL have parameter INT_BITS, default 4, integer bits of the fixed-point angle.
REQ-003 SHALL have parameter FRAC_BITS, default 8, fraction bits; W = INT_BITS+FRAC_BITS.
REQ-004 SHALL have parameter TWO_PI, default 12'h648 (W bits), 2*pi in the same fixed-point format.
REQ-005 SHALL have port Clk, input, 1, system clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port frame_clk_rising_edge, input, 1, one-cycle frame tick.
REQ-008 SHALL have port sync_zero, input, 1, zero all angles.
REQ-009 SHALL have port cfg_valid, input, 1, config request.
REQ-010 SHALL have port cfg_ready, output, 1, config accept.
REQ-011 SHALL have port cfg_axis, input, $clog2(N_AXES) (min 1), target axis.
REQ-012 SHALL have port cfg_step, input, W, per-frame increment.
REQ-013 SHALL have port cfg_dir, input, 1, 0 forward / 1 reverse.
REQ-014 SHALL have port cfg_mode, input, 2, STOP / RUN / STEP.
REQ-015 SHALL have port cfg_err, output, 1, one-cycle reject pulse.
REQ-016 SHALL have port theta, output, N_AXES x W, per-axis angle, axis i at bits [i*W +: W].
REQ-017 SHALL have port theta_valid, output, 1, one-cycle pulse marking a frame update.

Function
REQ-018 SHALL drive theta directly from the angle registers, with no combinational path from inputs.
REQ-019 SHALL, per axis, hold one of three modes: STOP (hold), RUN (advance every tick), STEP (advance on the next tick, then enter STOP in the same update).
REQ-020 SHALL, on a frame_clk_rising_edge sampled at cycle N, present the updated angles at cycle N+1 and pulse theta_valid at cycle N+1.
REQ-021 SHALL compute the forward update as s = angle+step, wider by 1 bit; result = s-TWO_PI if s >= TWO_PI, else s.
REQ-022 SHALL compute the reverse update as angle-step if angle >= step, else angle+TWO_PI-step.
REQ-023 SHALL keep every angle in [0, TWO_PI-1] at all times; wrap carries the remainder, with no snap to 0.
REQ-024 SHALL hold cfg_ready high except in cycles where frame_clk_rising_edge or sync_zero is high.
REQ-025 SHALL treat cfg_valid && cfg_ready as acceptance, writing step, dir and mode of axis cfg_axis at the next edge.
REQ-026 SHALL reject a config with cfg_step >= TWO_PI or cfg_axis >= N_AXES: no state change, cfg_err pulses at cycle N+1.
REQ-027 SHALL let cfg_valid wait while cfg_ready is low, with no loss of the request.
REQ-028 SHALL, on sync_zero, set all angles to 0 at the next edge, keep step/dir/mode, and not pulse theta_valid.
REQ-029 SHALL give sync_zero priority over a simultaneous frame tick, so the tick is dropped.
REQ-030 SHALL pulse theta_valid on every tick, even if all axes are in STOP.

Reset
REQ-031 SHALL, on Reset high at a Clk edge, set all angles to 0, all steps to 12'h01a (0.1 rad, scaled to W), dir forward, mode RUN, theta_valid 0 and cfg_err 0.
REQ-032 SHALL give Reset priority over sync_zero, frame tick and config; cfg_ready SHALL be low while Reset is high.
REQ-033 SHALL, when Reset is asserted mid-operation, discard any pending update or config.

Structure
REQ-034 SHALL place the mode enum (STOP, RUN, STEP), default INT/FRAC widths, TWO_PI_Q4_8 and STEP_0P1_Q4_8 in shared package rot_pkg.
REQ-035 SHALL instantiate one sub-module per axis, rotation_axis_acc (angle/step/dir/mode registers plus wrap arithmetic), through a generate loop.
REQ-036 SHALL keep the config decode, cfg_ready, cfg_err and theta_valid logic in the top level.

Verification
REQ-037 SHALL cover: after Reset, 4 ticks -> axis0 theta 0x01a, 0x034, 0x04e, 0x068; theta_valid pulses 4 times.
REQ-038 SHALL cover: axis0 at 0x640, step 0x01a forward, tick -> 0x012 (not 0x000).
REQ-039 SHALL cover: config axis1 dir=1 step 0x01a, axis1 at 0x010, tick -> 0x63e; axis0/axis2 unaffected.
REQ-040 SHALL cover: cfg_valid in the same cycle as a tick -> cfg_ready 0, accepted the next cycle; the tick uses the old step.
REQ-041 SHALL cover: cfg_step 0x648 -> cfg_err pulse, no state change; config axis2 mode STEP -> one advance, then 3 ticks with no change.
REQ-042 SHALL cover: sync_zero with a tick in the same cycle -> all theta 0, no theta_valid; Reset mid-config -> defaults restored.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared types and fixed-point constants for the multi-axis rotation angle generator.
// Angles are unsigned fixed-point values kept in [0, TWO_PI-1].
package rot_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } rot_mode_e;

  localparam int          DEF_INT_BITS  = 4;
  localparam int          DEF_FRAC_BITS = 8;
  localparam logic [11:0] TWO_PI_Q4_8   = 12'h648;
  localparam logic [11:0] STEP_0P1_Q4_8 = 12'h01a;

  // Rescale a Q.8 constant to a format with frac_bits fraction bits.
  function automatic int scale_q8(input int val_q8, input int frac_bits);
    if (frac_bits >= 8) begin
      return val_q8 <<< (frac_bits - 8);
    end else begin
      return val_q8 >>> (8 - frac_bits);
    end
  endfunction

endpackage

// File: rtl/rotation_axis_acc.sv
// One rotation axis: angle/step/dir/mode registers plus modulo-TWO_PI wrap arithmetic.
// Priority inside the axis: Reset > sync_zero > tick > config write.
module rotation_axis_acc
  import rot_pkg::*;
#(
  parameter int           W        = 12,
  parameter logic [W-1:0] TWO_PI   = W'(TWO_PI_Q4_8),
  parameter logic [W-1:0] STEP_RST = W'(STEP_0P1_Q4_8)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         tick,
  input  logic         sync_zero,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_step,
  input  logic         cfg_dir,
  input  logic [1:0]   cfg_mode,
  output logic [W-1:0] angle
);

  logic [W-1:0] angle_r;
  logic [W-1:0] step_r;
  logic         dir_r;
  rot_mode_e    mode_r;

  logic [W:0]   fwd_sum_s;
  logic [W:0]   rev_sum_s;
  logic [W-1:0] next_angle_s;
  rot_mode_e    next_mode_s;
  logic         advance_s;

  // Next angle for a tick; the wrap keeps the remainder instead of snapping to zero.
  always_comb begin
    fwd_sum_s    = {1'b0, angle_r} + {1'b0, step_r};
    rev_sum_s    = {1'b0, angle_r} + {1'b0, TWO_PI} - {1'b0, step_r};
    next_angle_s = angle_r;
    next_mode_s  = mode_r;
    advance_s    = 1'b0;
    case (mode_r)
      RUN: begin
        advance_s = 1'b1;
      end
      STEP: begin
        advance_s   = 1'b1;
        next_mode_s = STOP;
      end
      STOP: begin
        advance_s = 1'b0;
      end
      default: begin
        advance_s = 1'b0;
      end
    endcase
    if (!advance_s) begin
      next_angle_s = angle_r;
    end else if (!dir_r) begin
      if (fwd_sum_s >= {1'b0, TWO_PI}) begin
        next_angle_s = W'(fwd_sum_s - {1'b0, TWO_PI});
      end else begin
        next_angle_s = fwd_sum_s[W-1:0];
      end
    end else begin
      if (angle_r >= step_r) begin
        next_angle_s = angle_r - step_r;
      end else begin
        next_angle_s = rev_sum_s[W-1:0];
      end
    end
  end

  // Axis state registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      angle_r <= {W{1'b0}};
      step_r  <= STEP_RST;
      dir_r   <= 1'b0;
      mode_r  <= RUN;
    end else if (sync_zero) begin
      angle_r <= {W{1'b0}};
    end else if (tick) begin
      angle_r <= next_angle_s;
      mode_r  <= next_mode_s;
    end else if (cfg_we) begin
      step_r  <= cfg_step;
      dir_r   <= cfg_dir;
      mode_r  <= rot_mode_e'(cfg_mode);
    end else begin
      angle_r <= angle_r;
    end
  end

  assign angle = angle_r;

endmodule

// File: rtl/rotation_angle_gen.sv
// Multi-axis frame-ticked rotation angle generator with a ready/valid config port.
// Config is refused (cfg_ready low) in tick, sync_zero and Reset cycles so it never races an update.
module rotation_angle_gen
  import rot_pkg::*;
#(
  parameter int N_AXES    = 3,
  parameter int INT_BITS  = DEF_INT_BITS,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter logic [INT_BITS+FRAC_BITS-1:0] TWO_PI = (INT_BITS+FRAC_BITS)'(TWO_PI_Q4_8)
) (
  input  logic                                        Clk,
  input  logic                                        Reset,
  input  logic                                        frame_clk_rising_edge,
  input  logic                                        sync_zero,
  input  logic                                        cfg_valid,
  output logic                                        cfg_ready,
  input  logic [((N_AXES > 1) ? $clog2(N_AXES) : 1)-1:0] cfg_axis,
  input  logic [INT_BITS+FRAC_BITS-1:0]               cfg_step,
  input  logic                                        cfg_dir,
  input  logic [1:0]                                  cfg_mode,
  output logic                                        cfg_err,
  output logic [N_AXES*(INT_BITS+FRAC_BITS)-1:0]      theta,
  output logic                                        theta_valid
);

  localparam int           W        = INT_BITS + FRAC_BITS;
  localparam logic [W-1:0] STEP_RST = W'(scale_q8(int'(STEP_0P1_Q4_8), FRAC_BITS));

  logic              cfg_ready_s;
  logic              accept_s;
  logic              cfg_ok_s;
  logic [N_AXES-1:0] cfg_we_s;
  logic              theta_valid_r;
  logic              cfg_err_r;

  // Handshake and legality decode for the config port.
  always_comb begin
    cfg_ready_s = !Reset && !frame_clk_rising_edge && !sync_zero;
    accept_s    = cfg_valid && cfg_ready_s;
    cfg_ok_s    = (cfg_step < TWO_PI) && (32'(cfg_axis) < N_AXES);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_AXES; gi++) begin : g_axis
      assign cfg_we_s[gi] = accept_s && cfg_ok_s && (32'(cfg_axis) == gi);

      rotation_axis_acc #(
        .W        (W),
        .TWO_PI   (TWO_PI),
        .STEP_RST (STEP_RST)
      ) u_axis (
        .Clk       (Clk),
        .Reset     (Reset),
        .tick      (frame_clk_rising_edge),
        .sync_zero (sync_zero),
        .cfg_we    (cfg_we_s[gi]),
        .cfg_step  (cfg_step),
        .cfg_dir   (cfg_dir),
        .cfg_mode  (cfg_mode),
        .angle     (theta[gi*W +: W])
      );
    end
  endgenerate

  // Frame-update pulse and config reject pulse; a tick coinciding with sync_zero is dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      theta_valid_r <= 1'b0;
      cfg_err_r     <= 1'b0;
    end else begin
      theta_valid_r <= frame_clk_rising_edge && !sync_zero;
      cfg_err_r     <= accept_s && !cfg_ok_s;
    end
  end

  assign cfg_ready   = cfg_ready_s;
  assign cfg_err     = cfg_err_r;
  assign theta_valid = theta_valid_r;

endmodule

// File: tb/tb_rotation_angle_gen.sv
// Directed plus randomized bench for rotation_angle_gen against a modulo-arithmetic angle model.
module tb_rotation_angle_gen;

  localparam int TP = 'h648;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame;
  logic        sync_zero;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_axis;
  logic [11:0] cfg_step;
  logic        cfg_dir;
  logic [1:0]  cfg_mode;
  logic        cfg_err;
  logic [35:0] theta;
  logic        theta_valid;

  int tests = 0;
  int fails = 0;

  int m_angle [3];
  int m_step  [3];
  int m_dir   [3];
  int m_mode  [3];

  always #5 Clk = ~Clk;

  rotation_angle_gen dut (
    .Clk                   (Clk),
    .Reset                 (Reset),
    .frame_clk_rising_edge (frame),
    .sync_zero             (sync_zero),
    .cfg_valid             (cfg_valid),
    .cfg_ready             (cfg_ready),
    .cfg_axis              (cfg_axis),
    .cfg_step              (cfg_step),
    .cfg_dir               (cfg_dir),
    .cfg_mode              (cfg_mode),
    .cfg_err               (cfg_err),
    .theta                 (theta),
    .theta_valid           (theta_valid)
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] exp_theta();
    logic [35:0] r;
    for (int i = 0; i < 3; i++) r[i*12 +: 12] = 12'(m_angle[i]);
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_angle[i] = 0; m_step[i] = 'h1a; m_dir[i] = 0; m_mode[i] = 1;
    end
  endfunction

  // Angles live on a circle of TP units: forward/reverse are plain modular add/subtract.
  function automatic void model_tick();
    for (int i = 0; i < 3; i++) begin
      if (m_mode[i] != 0) begin
        if (m_dir[i] == 0) m_angle[i] = (m_angle[i] + m_step[i]) % TP;
        else               m_angle[i] = (m_angle[i] - m_step[i] + TP) % TP;
        if (m_mode[i] == 2) m_mode[i] = 0;
      end
    end
  endfunction

  task automatic do_tick(input string tag);
    @(negedge Clk);
    frame = 1'b1;
    #1 chk({tag, "_rdy"}, cfg_ready, 1'b0);
    @(negedge Clk);
    frame = 1'b0;
    model_tick();
    #1;
    chk({tag, "_tv"}, theta_valid, 1'b1);
    chk({tag, "_theta"}, theta, exp_theta());
  endtask

  task automatic do_cfg(input int axis, input int step, input int dir, input int mode, input string tag);
    bit err;
    @(negedge Clk);
    cfg_valid = 1'b1; cfg_axis = 2'(axis); cfg_step = 12'(step);
    cfg_dir = 1'(dir); cfg_mode = 2'(mode);
    #1 chk({tag, "_rdy"}, cfg_ready, 1'b1);
    @(negedge Clk);
    cfg_valid = 1'b0;
    err = (step >= TP) || (axis >= 3);
    if (!err) begin
      m_step[axis] = step; m_dir[axis] = dir; m_mode[axis] = mode;
    end
    #1;
    chk({tag, "_err"}, cfg_err, 1'(err));
    chk({tag, "_tv0"}, theta_valid, 1'b0);
    chk({tag, "_theta"}, theta, exp_theta());
  endtask

  task automatic do_sync(input bit with_tick, input string tag);
    @(negedge Clk);
    sync_zero = 1'b1; frame = with_tick;
    #1 chk({tag, "_rdy"}, cfg_ready, 1'b0);
    @(negedge Clk);
    sync_zero = 1'b0; frame = 1'b0;
    for (int i = 0; i < 3; i++) m_angle[i] = 0;
    #1;
    chk({tag, "_tv0"}, theta_valid, 1'b0);
    chk({tag, "_theta"}, theta, exp_theta());
  endtask

  initial begin
    int op;
    Reset = 1'b1; frame = 1'b0; sync_zero = 1'b0; cfg_valid = 1'b0;
    cfg_axis = 2'd0; cfg_step = 12'h000; cfg_dir = 1'b0; cfg_mode = 2'd0;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    #1 chk("rst_rdy_low", cfg_ready, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst_theta", theta, 36'h0);
    chk("rst_tv", theta_valid, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_rdy", cfg_ready, 1'b1);

    // Default step advances axis0 by 0x01a per tick.
    for (int k = 0; k < 4; k++) begin
      logic [11:0] ax0_exp;
      ax0_exp = 12'(26 * (k + 1));
      do_tick("def_tick");
      chk("def_ax0", theta[11:0], ax0_exp);
    end

    // Forward wrap keeps the remainder.
    do_sync(1'b0, "sync_a");
    do_cfg(0, 'h640, 0, 1, "cfg_640");
    do_tick("to_640");
    chk("ax0_640", theta[11:0], 12'h640);
    do_cfg(0, 'h01a, 0, 1, "cfg_01a");
    do_tick("wrap_fwd");
    chk("ax0_wrap", theta[11:0], 12'h012);

    // Reverse wrap on axis1 with the other axes stopped.
    do_sync(1'b0, "sync_b");
    do_cfg(0, 'h01a, 0, 0, "ax0_stop");
    do_cfg(2, 'h01a, 0, 0, "ax2_stop");
    do_cfg(1, 'h010, 0, 1, "ax1_010");
    do_tick("to_010");
    chk("ax1_010", theta[23:12], 12'h010);
    do_cfg(1, 'h01a, 1, 1, "ax1_rev");
    do_tick("wrap_rev");
    chk("ax1_wrap", theta[23:12], 12'h63e);
    chk("ax0_held", theta[11:0], 12'h000);
    chk("ax2_held", theta[35:24], 12'h000);

    // Config arriving with a tick waits one cycle; the tick uses the old step.
    do_cfg(0, 'h01a, 0, 1, "ax0_run");
    @(negedge Clk);
    frame = 1'b1; cfg_valid = 1'b1; cfg_axis = 2'd0; cfg_step = 12'h020;
    cfg_dir = 1'b0; cfg_mode = 2'd1;
    #1 chk("coll_rdy0", cfg_ready, 1'b0);
    @(negedge Clk);
    frame = 1'b0;
    model_tick();
    #1;
    chk("coll_tv", theta_valid, 1'b1);
    chk("coll_theta", theta, exp_theta());
    chk("coll_rdy1", cfg_ready, 1'b1);
    @(negedge Clk);
    cfg_valid = 1'b0;
    m_step[0] = 'h20;
    #1 chk("coll_err", cfg_err, 1'b0);
    do_tick("coll_newstep");

    // Rejected configs, then a single-step axis.
    do_cfg(0, 'h648, 0, 1, "bad_step");
    do_cfg(3, 'h010, 0, 1, "bad_axis");
    do_cfg(2, 'h01a, 0, 2, "ax2_step");
    do_tick("step_adv");
    for (int k = 0; k < 3; k++) do_tick("step_hold");

    // sync_zero beats a simultaneous tick; Reset discards a pending config.
    do_sync(1'b1, "sync_tick");
    @(negedge Clk);
    cfg_valid = 1'b1; cfg_axis = 2'd1; cfg_step = 12'h100; cfg_dir = 1'b1; cfg_mode = 2'd0;
    Reset = 1'b1;
    #1 chk("rstcfg_rdy0", cfg_ready, 1'b0);
    @(negedge Clk);
    Reset = 1'b0; cfg_valid = 1'b0;
    model_reset();
    #1;
    chk("rstcfg_err", cfg_err, 1'b0);
    chk("rstcfg_theta", theta, exp_theta());
    do_tick("rstcfg_t1");
    do_tick("rstcfg_t2");

    // Randomized mix of ticks, configs (some illegal) and syncs.
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) do_tick("rnd_tick");
      else if (op <= 8)
        do_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 'h6ff)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "rnd_cfg");
      else do_sync(1'($urandom_range(0, 1)), "rnd_sync");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
